uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver for the risc8 SoC serial_rx pin. Runs in the 12 MHz core clock domain.
- Synchronises the asynchronous line, finds the start bit and samples each bit at its centre.
- Holds the received byte in a one-deep register with a valid/ready handshake toward the SoC bus logic.
- Flags framing errors, overruns and start-bit glitches.

Parameters:
- DIVISOR, 104, core clocks per bit (12 MHz / 115200 baud); legal range 4..65535.
- HALF, DIVISOR/2 (integer floor), clocks from start-edge detection to start-bit centre; derived, not overridden.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- serial_rx  input  1  asynchronous line, idle high
- data  output  8  received byte, stable while valid=1
- valid  output  1  data holds an unread byte
- ready  input  1  consumer takes the byte this cycle when valid=1
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being read
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset. All state changes on the posedge of clk.
- Reset values: data=0, valid=0, framing_err=0, overrun=0, busy=0, state=IDLE, bit counter=0, baud counter=0, both synchroniser flops=1.
- Reset mid-frame discards the partial byte, and any held byte, with no error pulse.
- Synchroniser: two flops, serial_rx -> s1 -> rx_s. All logic uses rx_s only, which adds 2 cycles of input latency.
- Baud counter: 16-bit down-counter. "Tick" means the counter equals 0, and the counter reloads on every tick.
- IDLE:
  - On rx_s=0, load the counter with HALF-1 and go to START.
- START:
  - On tick, if rx_s=0: reload DIVISOR-1, clear the bit index, go to DATA.
  - On tick, if rx_s=1: the low was a glitch. Go to IDLE with no output and no error.
- DATA:
  - On tick, shift rx_s in LSB-first (shift right, new bit enters bit 7) and reload DIVISOR-1.
  - When the 8th bit has been taken (index 7), go to STOP. Otherwise increment the bit index.
- STOP:
  - On tick with rx_s=1, deliver the byte (rules below) and go to IDLE.
  - On tick with rx_s=0, pulse framing_err for 1 cycle, drop the byte and go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering frames.
- Delivery, evaluated in the stop-tick cycle; outputs update on the next edge:
  - valid=0: load data, set valid=1.
  - valid=1 and ready=1: the old byte is consumed, the new byte is loaded, valid stays 1, no overrun.
  - valid=1 and ready=0: pulse overrun for 1 cycle, keep the old data, drop the new byte.
- Handshake: valid clears the cycle after valid&ready unless a new byte loads in that same cycle. ready while valid=0 is ignored.
- Latency: the line's falling edge reaches rx_s after 2 cycles. valid rises 1 + HALF + 9*DIVISOR cycles after rx_s falls (1 edge cycle + HALF to the start-bit centre + 9 bit times, including the stop-bit tick).
- Back-to-back frames: IDLE is entered at the stop-bit centre, so the next start edge half a bit later is caught with no lost frame.
- Width rules: bit index is 3 bits. HALF-1 is computed at elaboration; DIVISOR≥4 guarantees HALF-1≥1.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, START, DATA, STOP, WAIT_IDLE; 3 bits);
  - the baud-rate constants for the 12 MHz clock (DIVISOR_115200=104, DIVISOR_9600=1250);
  - the counter width of 16.
- One natural sub-module: uart_rx_sync, the 2-flop synchroniser with a reset value of 1, reused by other async inputs such as pin_b.
- The baud counter stays inline.

Test Plan:
- Byte 0x55 at DIVISOR=104, ready held high: data=0x55, valid high for exactly 1 cycle, 2+1+52+936 cycles after the falling edge; no error pulses.
- Frames 0xA5 then 0x3C back-to-back with zero idle between stop and start, ready held low until both frames finish: data=0xA5 is held, overrun pulses once at the second stop tick, 0x3C is dropped. Repeat with ready high: both bytes are delivered in order, no overrun.
- Frame 0x81 with the stop bit driven low, then the line held low 3 bit-times, then high, then 0x00 sent: framing_err pulses once, valid stays 0, the design stays in WAIT_IDLE until the line rises, then 0x00 is received normally.
- 20-cycle low glitch on serial_rx from idle: busy rises, returns to IDLE after the start check, valid=0 and no error pulses.
- reset asserted for 1 cycle mid-DATA while sending 0xFF, with valid=1 holding 0x12: all outputs return to reset values, 0x12 is discarded, the rest of the frame produces no valid, and the next full 0x7E frame is received correctly.
- ready pulse coincident with the stop tick while valid=1 (data 0x11), incoming byte 0x22: the cycle after shows data=0x22, valid=1, overrun=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial receiver and its helpers.
//   state_t        : receiver FSM state encoding (3 bits)
//   CNT_W          : width of the baud down-counter
//   DIVISOR_115200 : core clocks per bit at 115200 baud from 12 MHz
//   DIVISOR_9600   : core clocks per bit at 9600 baud from 12 MHz
package uart_rx_pkg;

  localparam int CNT_W          = 16;
  localparam int DIVISOR_115200 = 104;
  localparam int DIVISOR_9600   = 1250;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input pin.
//   clk      : destination clock
//   reset    : synchronous, active-high; both flops reset to 1 (idle level)
//   async_in : asynchronous input
//   sync_out : synchronised copy, two clocks behind async_in
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
    end else begin
      s1_reg <= async_in;
      s2_reg <= s1_reg;
    end
  end

  assign sync_out = s2_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-deep holding register.
//   clk         : core clock
//   reset       : synchronous, active-high
//   serial_rx   : asynchronous line, idle high
//   data        : received byte, stable while valid=1
//   valid       : data holds an unread byte
//   ready       : consumer takes the byte this cycle when valid=1
//   framing_err : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, byte finished while holding register full
//   busy        : receiver is in any state other than IDLE
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIVISOR = DIVISOR_115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF = DIVISOR / 2;
  // Loads are one less than the interval because the tick is the zero count.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIVISOR - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (serial_rx),
    .sync_out (rx_s)
  );

  state_t           state_reg,       state_next;
  logic [CNT_W-1:0] cnt_reg,         cnt_next;
  logic [2:0]       bit_idx_reg,     bit_idx_next;
  logic [7:0]       shift_reg,       shift_next;
  logic [7:0]       data_reg,        data_next;
  logic             valid_reg,       valid_next;
  logic             framing_err_reg, framing_err_next;
  logic             overrun_reg,     overrun_next;
  logic             tick;

  assign tick = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      data_reg        <= data_next;
      valid_reg       <= valid_next;
      framing_err_reg <= framing_err_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    bit_idx_next     = bit_idx_reg;
    shift_next       = shift_reg;
    data_next        = data_reg;
    valid_next       = valid_reg;
    framing_err_next = 1'b0;
    overrun_next     = 1'b0;

    // Consumer handshake; a delivery below in the same cycle overrides it.
    if (valid_reg && ready) begin
      valid_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end

      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_next     = BIT_LOAD;
            bit_idx_next = '0;
            state_next   = DATA;
          end else begin
            // Line went back high before mid-bit: glitch, not a frame.
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DATA: begin
        if (tick) begin
          shift_next = {rx_s, shift_reg[7:1]};
          cnt_next   = BIT_LOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          cnt_next = BIT_LOAD;
          if (rx_s) begin
            // A byte being read this cycle frees the register for the new one.
            if (!valid_reg || ready) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
            // Leaving at mid stop bit leaves half a bit to catch the next start.
            state_next = IDLE;
          end else begin
            framing_err_next = 1'b1;
            state_next       = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line returns high so a break cannot retrigger.
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data        = data_reg;
  assign valid       = valid_reg;
  assign framing_err = framing_err_reg;
  assign overrun     = overrun_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 115200 baud from a 12 MHz clock.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int D = DIVISOR_115200;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_rx = 1'b1;
  logic       ready     = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.DIVISOR(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_rx   (serial_rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Monitor samples at posedge, i.e. the same values the DUT sees.
  int         cyc        = 0;
  int         vcnt       = 0;
  int         ovr_cnt    = 0;
  int         fe_cnt     = 0;
  int         rise_cyc   = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) begin
    if (valid) vcnt <= vcnt + 1;
    if (valid && !valid_prev) rise_cyc <= cyc;
    if (valid && ready) begin
      got_q.push_back(data);
      $display("rx byte %02h consumed at cycle %0d", data, cyc);
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (framing_err) fe_cnt <= fe_cnt + 1;
    valid_prev <= valid;
    cyc        <= cyc + 1;
  end

  int err_cnt = 0;
  int chk_cnt = 0;
  int fall_cyc = 0;
  int q0, v0, o0, f0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i >= 0 && i < got_q.size()) return {24'd0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Call at a negedge; leaves the line at the stop level.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    $display("tx byte %02h stop=%0d at cycle %0d", b, stop, cyc);
    serial_rx = 1'b0;
    fall_cyc  = cyc;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (D) @(negedge clk);
    end
    serial_rx = stop;
    repeat (D) @(negedge clk);
  endtask

  task automatic snap();
    q0 = got_q.size();
    v0 = vcnt;
    o0 = ovr_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fe", {31'd0, framing_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, ready high
    ready = 1'b1;
    snap();
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_count", got_q.size() - q0, 32'd1);
    check("t1_data", q_at(q0), 32'h55);
    check("t1_latency", rise_cyc - fall_cyc, 32'd991);
    check("t1_valid_cycles", vcnt - v0, 32'd1);
    check("t1_ovr", ovr_cnt - o0, 32'd0);
    check("t1_fe", fe_cnt - f0, 32'd0);

    // Back-to-back, ready low: second byte overruns
    ready = 1'b0;
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_data", {24'd0, data}, 32'hA5);
    check("t2_ovr", ovr_cnt - o0, 32'd1);
    check("t2_count", got_q.size() - q0, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t2_drain", q_at(q0), 32'hA5);
    check("t2_valid_clr", {31'd0, valid}, 32'd0);

    // Back-to-back, ready high: both delivered
    ready = 1'b1;
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_count", got_q.size() - q0, 32'd2);
    check("t3_first", q_at(q0), 32'hA5);
    check("t3_second", q_at(q0 + 1), 32'h3C);
    check("t3_ovr", ovr_cnt - o0, 32'd0);

    // Framing error followed by a break, then a clean 0x00
    snap();
    send_byte(8'h81, 1'b0);
    repeat (3 * D) @(negedge clk);
    check("t4_busy_break", {31'd0, busy}, 32'd1);
    check("t4_fe", fe_cnt - f0, 32'd1);
    check("t4_no_valid", vcnt - v0, 32'd0);
    serial_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_count", got_q.size() - q0, 32'd1);
    check("t4_data", q_at(q0), 32'h00);
    check("t4_fe_total", fe_cnt - f0, 32'd1);

    // Start-bit glitch
    snap();
    serial_rx = 1'b0;
    repeat (20) @(negedge clk);
    serial_rx = 1'b1;
    check("t5_busy_start", {31'd0, busy}, 32'd1);
    repeat (100) @(negedge clk);
    check("t5_busy_end", {31'd0, busy}, 32'd0);
    check("t5_no_valid", vcnt - v0, 32'd0);
    check("t5_fe", fe_cnt - f0, 32'd0);
    check("t5_ovr", ovr_cnt - o0, 32'd0);

    // Reset mid-frame with a held byte
    ready = 1'b0;
    send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_held_valid", {31'd0, valid}, 32'd1);
    check("t6_held_data", {24'd0, data}, 32'h12);
    snap();
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (4 * D + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_data", {24'd0, data}, 32'h00);
        check("t6_rst_valid", {31'd0, valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        v0 = vcnt;
      end
    join
    repeat (20) @(negedge clk);
    check("t6_no_valid", vcnt - v0, 32'd0);
    check("t6_fe", fe_cnt - f0, 32'd0);
    check("t6_ovr", ovr_cnt - o0, 32'd0);
    ready = 1'b1;
    snap();
    send_byte(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_count", got_q.size() - q0, 32'd1);
    check("t6_data", q_at(q0), 32'h7E);

    // ready coincident with the stop tick while a byte is held
    ready = 1'b0;
    send_byte(8'h11, 1'b1);
    repeat (20) @(negedge clk);
    check("t7_held", {24'd0, data}, 32'h11);
    snap();
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (990) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("t7_data", {24'd0, data}, 32'h22);
        check("t7_valid", {31'd0, valid}, 32'd1);
        check("t7_ovr_now", {31'd0, overrun}, 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    check("t7_ovr", ovr_cnt - o0, 32'd0);
    check("t7_consumed", q_at(q0), 32'h11);
    check("t7_still", {24'd0, data}, 32'h22);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
